// File: rtl/pe_gen_pkg.sv
// pe_gen_pkg: shared definitions for the parametrised systolic processing element.
//
// Contents:
//   MAX_DATA_W / WIDE_W  - widest supported data word and the working width of
//                          the saturate/truncate helper
//   MODE_* / LAT_BASE    - result-mode and latency constants
//   sat_res_t            - value + overflow bit returned by sat_trunc
//   round_half_const()   - 2^(frac_w-1), the round-half-up bias
//   sat_trunc()          - clamp (saturate) or wrap (truncate) a wide signed
//                          value to 'width' bits, reporting whether it changed
package pe_gen_pkg;

    localparam int MAX_DATA_W = 32;
    localparam int WIDE_W     = 2 * MAX_DATA_W + 1;

    localparam bit MODE_SATURATE = 1'b1;
    localparam bit MODE_WRAP     = 1'b0;

    // Result latency without the optional product register.
    localparam int LAT_BASE = 1;

    typedef struct packed {
        logic signed [WIDE_W-1:0] result;
        logic                     ovf;
    } sat_res_t;

    function automatic longint round_half_const(input int frac_w);
        return longint'(1) <<< (frac_w - 1);
    endfunction

    // The returned result is always sign-extended from 'width' bits, so the
    // low 'width' bits are the encoded word and the rest are sign copies.
    function automatic sat_res_t sat_trunc(input logic signed [WIDE_W-1:0] value,
                                           input int                       width,
                                           input bit                       saturate);
        sat_res_t                 res;
        logic signed [WIDE_W-1:0] max_v;
        logic signed [WIDE_W-1:0] min_v;
        logic signed [WIDE_W-1:0] wrapped;
        max_v   = (WIDE_W'(1) << (width - 1)) - WIDE_W'(1);
        min_v   = ~max_v;
        wrapped = (value <<< (WIDE_W - width)) >>> (WIDE_W - width);
        res.result = value;
        res.ovf    = 1'b0;
        if (saturate) begin
            if (value > max_v) begin
                res.result = max_v;
                res.ovf    = 1'b1;
            end else if (value < min_v) begin
                res.result = min_v;
                res.ovf    = 1'b1;
            end
        end else begin
            res.result = wrapped;
            res.ovf    = (wrapped != value);
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_gen_if.sv
// pe_gen_if: signal bundle of one processing element.
//
// Stream semantics: valid-only, no backpressure. pe_valid_in qualifies the
// pe_input_in / pe_psum_in pair in the cycle it is high; pe_valid_out
// qualifies pe_psum_out the same way. The only stall is pe_enabled = 0,
// which freezes the whole PE (and forces pe_valid_out low).
//
// Modports:
//   master - the array / bench side driving the PE
//   slave  - the PE itself
interface pe_gen_if #(
    parameter int DATA_W = 16
) ();
    logic              pe_enabled;
    logic              pe_valid_in;
    logic              pe_accept_w_in;
    logic              pe_switch_in;
    logic              pe_bypass_in;
    logic              pe_clear_ovf_in;
    logic [DATA_W-1:0] pe_input_in;
    logic [DATA_W-1:0] pe_weight_in;
    logic [DATA_W-1:0] pe_psum_in;

    logic              pe_valid_out;
    logic              pe_switch_out;
    logic [DATA_W-1:0] pe_input_out;
    logic [DATA_W-1:0] pe_weight_out;
    logic [DATA_W-1:0] pe_psum_out;
    logic              pe_overflow_out;

    modport master (
        output pe_enabled, pe_valid_in, pe_accept_w_in, pe_switch_in,
               pe_bypass_in, pe_clear_ovf_in, pe_input_in, pe_weight_in, pe_psum_in,
        input  pe_valid_out, pe_switch_out, pe_input_out, pe_weight_out,
               pe_psum_out, pe_overflow_out
    );

    modport slave (
        input  pe_enabled, pe_valid_in, pe_accept_w_in, pe_switch_in,
               pe_bypass_in, pe_clear_ovf_in, pe_input_in, pe_weight_in, pe_psum_in,
        output pe_valid_out, pe_switch_out, pe_input_out, pe_weight_out,
               pe_psum_out, pe_overflow_out
    );
endinterface

// File: rtl/pe_gen_mac.sv
// pe_gen_mac: multiply, round-half-up, optional product register, add and
// saturate/wrap for one processing element.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   en            0 holds every register (valid_out is forced to 0)
//   valid_in      act_in / psum_in pair valid
//   bypass_in     pass psum_in through unmodified
//   act_in        activation
//   weight_in     active weight (the value before the current edge)
//   psum_in       partial sum from above
//   valid_out     result valid, 1 + MUL_PIPE cycles after valid_in
//   psum_out      result
//   ovf_set       high when the result captured on this edge was clamped or
//                 wrapped; consumed by the sticky flag in the parent
module pe_gen_mac
    import pe_gen_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int MUL_PIPE = 0,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              valid_in,
    input  logic              bypass_in,
    input  logic [DATA_W-1:0] act_in,
    input  logic [DATA_W-1:0] weight_in,
    input  logic [DATA_W-1:0] psum_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] psum_out,
    output logic              ovf_set
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic signed [PROD_W-1:0] RND = PROD_W'(round_half_const(FRAC_W));

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] rnd_val;

    // Operands of the final stage, either straight from the inputs or from
    // the product register.
    logic signed [PROD_W-1:0] st_r;
    logic        [DATA_W-1:0] st_psum;
    logic                     st_valid;
    logic                     st_bypass;

    logic signed [SUM_W-1:0]  sum;
    sat_res_t                 sat;
    logic        [DATA_W-1:0] sat_low;
    logic        [DATA_W-1:0] psum_next;

    assign prod    = PROD_W'($signed(act_in)) * PROD_W'($signed(weight_in));
    // The bias cannot overflow: |prod| <= 2^(PROD_W-2) leaves headroom.
    assign rnd_val = (prod + RND) >>> FRAC_W;

    generate
        if (MUL_PIPE != 0) begin : g_pipe
            logic signed [PROD_W-1:0] s1_r;
            logic        [DATA_W-1:0] s1_psum;
            logic                     s1_valid;
            logic                     s1_bypass;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s1_r      <= '0;
                    s1_psum   <= '0;
                    s1_valid  <= 1'b0;
                    s1_bypass <= 1'b0;
                end else if (en) begin
                    s1_r      <= rnd_val;
                    s1_psum   <= psum_in;
                    s1_valid  <= valid_in;
                    s1_bypass <= bypass_in;
                end
            end

            assign st_r      = s1_r;
            assign st_psum   = s1_psum;
            assign st_valid  = s1_valid;
            assign st_bypass = s1_bypass;
        end else begin : g_comb
            assign st_r      = rnd_val;
            assign st_psum   = psum_in;
            assign st_valid  = valid_in;
            assign st_bypass = bypass_in;
        end
    endgenerate

    assign sum     = SUM_W'(st_r) + SUM_W'($signed(st_psum));
    assign sat     = sat_trunc(WIDE_W'(sum), DATA_W, (SATURATE != 0) ? MODE_SATURATE : MODE_WRAP);
    assign sat_low = sat.result[DATA_W-1:0];

    always_comb begin
        psum_next = '0;
        if (st_valid) begin
            psum_next = st_bypass ? st_psum : sat_low;
        end
    end

    // The re-extension compare covers the full helper result; it only
    // disagrees if the upper bits are not sign copies of the encoded word.
    assign ovf_set = en & st_valid & ~st_bypass &
                     (sat.ovf | (sat.result != WIDE_W'($signed(sat_low))));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out <= 1'b0;
            psum_out  <= '0;
        end else if (en) begin
            valid_out <= st_valid;
            psum_out  <= psum_next;
        end else begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: rtl/pe_gen.sv
// pe_gen: parametrised systolic processing element for the tiny-tpu array,
// signed fixed point Q(DATA_W-FRAC_W).FRAC_W.
//
// Ports:
//   clk   clock, all state on the rising edge
//   rst   asynchronous active-low reset
//   pe    pe_gen_if.slave bundle:
//         inputs  pe_enabled, pe_valid_in, pe_accept_w_in, pe_switch_in,
//                 pe_bypass_in, pe_clear_ovf_in, pe_input_in, pe_weight_in,
//                 pe_psum_in
//         outputs pe_valid_out, pe_switch_out, pe_input_out, pe_weight_out,
//                 pe_psum_out, pe_overflow_out
//
// Holds the double-buffered weights, the east/south forwarding registers and
// the sticky overflow flag; arithmetic lives in pe_gen_mac.
module pe_gen
    import pe_gen_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int MUL_PIPE = 0,
    parameter int SATURATE = 1
) (
    input  logic    clk,
    input  logic    rst,
    pe_gen_if.slave pe
);
    logic [DATA_W-1:0] weight_active;
    logic [DATA_W-1:0] weight_inactive;
    logic [DATA_W-1:0] weight_out_q;
    logic [DATA_W-1:0] input_out_q;
    logic              switch_out_q;
    logic              ovf_q;

    logic              mac_valid;
    logic [DATA_W-1:0] mac_psum;
    logic              mac_ovf_set;

    // The MAC is fed the active weight as it stands before the edge, so a
    // switch only takes effect on the following input.
    pe_gen_mac #(
        .DATA_W  (DATA_W),
        .FRAC_W  (FRAC_W),
        .MUL_PIPE(MUL_PIPE),
        .SATURATE(SATURATE)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .en       (pe.pe_enabled),
        .valid_in (pe.pe_valid_in),
        .bypass_in(pe.pe_bypass_in),
        .act_in   (pe.pe_input_in),
        .weight_in(weight_active),
        .psum_in  (pe.pe_psum_in),
        .valid_out(mac_valid),
        .psum_out (mac_psum),
        .ovf_set  (mac_ovf_set)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weight_active   <= '0;
            weight_inactive <= '0;
            weight_out_q    <= '0;
            input_out_q     <= '0;
            switch_out_q    <= 1'b0;
            ovf_q           <= 1'b0;
        end else if (pe.pe_enabled) begin
            // Switch reads the pre-edge inactive value, so a simultaneous
            // accept lands in inactive while active gets the old one.
            if (pe.pe_switch_in) begin
                weight_active <= weight_inactive;
            end
            if (pe.pe_accept_w_in) begin
                weight_inactive <= pe.pe_weight_in;
                weight_out_q    <= pe.pe_weight_in;
            end
            switch_out_q <= pe.pe_switch_in;
            input_out_q  <= pe.pe_input_in;
            // Set has priority over clear.
            if (mac_ovf_set) begin
                ovf_q <= 1'b1;
            end else if (pe.pe_clear_ovf_in) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign pe.pe_valid_out    = mac_valid;
    assign pe.pe_psum_out     = mac_psum;
    assign pe.pe_switch_out   = switch_out_q;
    assign pe.pe_input_out    = input_out_q;
    assign pe.pe_weight_out   = weight_out_q;
    assign pe.pe_overflow_out = ovf_q;

endmodule

// File: tb/tb_pe_gen.sv
// tb_pe_gen: directed + randomised bench for pe_gen.
// Three instances share one stimulus: dut0 (latency 1, saturating),
// dut1 (product register, latency 2, saturating), dut2 (latency 1, wrapping).
module tb_pe_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic        en  = 1'b0;
    logic        vld = 1'b0;
    logic        acc = 1'b0;
    logic        sw  = 1'b0;
    logic        byp = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] act = '0;
    logic [15:0] wgt = '0;
    logic [15:0] psm = '0;

    pe_gen_if #(.DATA_W(16)) if0 ();
    pe_gen_if #(.DATA_W(16)) if1 ();
    pe_gen_if #(.DATA_W(16)) if2 ();

    assign if0.pe_enabled = en;      assign if1.pe_enabled = en;      assign if2.pe_enabled = en;
    assign if0.pe_valid_in = vld;    assign if1.pe_valid_in = vld;    assign if2.pe_valid_in = vld;
    assign if0.pe_accept_w_in = acc; assign if1.pe_accept_w_in = acc; assign if2.pe_accept_w_in = acc;
    assign if0.pe_switch_in = sw;    assign if1.pe_switch_in = sw;    assign if2.pe_switch_in = sw;
    assign if0.pe_bypass_in = byp;   assign if1.pe_bypass_in = byp;   assign if2.pe_bypass_in = byp;
    assign if0.pe_clear_ovf_in = clr; assign if1.pe_clear_ovf_in = clr; assign if2.pe_clear_ovf_in = clr;
    assign if0.pe_input_in = act;    assign if1.pe_input_in = act;    assign if2.pe_input_in = act;
    assign if0.pe_weight_in = wgt;   assign if1.pe_weight_in = wgt;   assign if2.pe_weight_in = wgt;
    assign if0.pe_psum_in = psm;     assign if1.pe_psum_in = psm;     assign if2.pe_psum_in = psm;

    pe_gen #(.DATA_W(16), .FRAC_W(8), .MUL_PIPE(0), .SATURATE(1)) dut0 (.clk(clk), .rst(rst), .pe(if0));
    pe_gen #(.DATA_W(16), .FRAC_W(8), .MUL_PIPE(1), .SATURATE(1)) dut1 (.clk(clk), .rst(rst), .pe(if1));
    pe_gen #(.DATA_W(16), .FRAC_W(8), .MUL_PIPE(0), .SATURATE(0)) dut2 (.clk(clk), .rst(rst), .pe(if2));

    // ---------------- scoreboard / model state ----------------
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [15:0] exp_q2[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mdl_active     = '0;
    logic [15:0] mdl_inactive   = '0;
    logic        mdl_ovf0       = 1'b0;
    logic        mdl_ovf2       = 1'b0;
    logic [15:0] exp_weight_out = '0;
    logic [15:0] exp_input_out  = '0;
    logic        exp_switch_out = 1'b0;
    logic        exp_valid0     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Q8.8 reference: {overflow, result}
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] w,
                                          input logic [15:0] ps, input bit sat);
        longint      p;
        longint      r;
        longint      s;
        logic [15:0] lo;
        p  = longint'($signed(a)) * longint'($signed(w));
        r  = (p + 64'sd128) >>> 8;
        s  = r + longint'($signed(ps));
        lo = s[15:0];
        if (sat) begin
            if (s > 64'sd32767)  return {1'b1, 16'h7fff};
            if (s < -64'sd32768) return {1'b1, 16'h8000};
            return {1'b0, lo};
        end
        return {(longint'($signed(lo)) != s), lo};
    endfunction

    // Output monitor: every produced result is popped and compared.
    always @(negedge clk) begin
        if (rst) begin
            if (if0.pe_valid_out) begin
                check("q0_has_entry", 32'(exp_q0.size() != 0), 32'd1);
                if (exp_q0.size() != 0) check("psum0", 32'(if0.pe_psum_out), 32'(exp_q0.pop_front()));
            end
            if (if1.pe_valid_out) begin
                check("q1_has_entry", 32'(exp_q1.size() != 0), 32'd1);
                if (exp_q1.size() != 0) check("psum1", 32'(if1.pe_psum_out), 32'(exp_q1.pop_front()));
            end
            if (if2.pe_valid_out) begin
                check("q2_has_entry", 32'(exp_q2.size() != 0), 32'd1);
                if (exp_q2.size() != 0) check("psum2", 32'(if2.pe_psum_out), 32'(exp_q2.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_fwd();
        check("valid_out0", 32'(if0.pe_valid_out), 32'(exp_valid0));
        check("switch_out", 32'(if0.pe_switch_out), 32'(exp_switch_out));
        check("input_out", 32'(if0.pe_input_out), 32'(exp_input_out));
        check("weight_out", 32'(if0.pe_weight_out), 32'(exp_weight_out));
        check("ovf0", 32'(if0.pe_overflow_out), 32'(mdl_ovf0));
        check("ovf2", 32'(if2.pe_overflow_out), 32'(mdl_ovf2));
    endtask

    // Applies the current inputs for one clock edge, updating the model first.
    task automatic tick();
        logic [16:0] r0;
        logic [16:0] r2;
        r0 = '0;
        r2 = '0;
        if (en) begin
            if (vld) begin
                if (byp) begin
                    r0 = {1'b0, psm};
                    r2 = r0;
                end else begin
                    r0 = model(act, mdl_active, psm, 1'b1);
                    r2 = model(act, mdl_active, psm, 1'b0);
                end
                exp_q0.push_back(r0[15:0]);
                exp_q1.push_back(r0[15:0]);
                exp_q2.push_back(r2[15:0]);
            end
            mdl_ovf0 = r0[16] ? 1'b1 : (clr ? 1'b0 : mdl_ovf0);
            mdl_ovf2 = r2[16] ? 1'b1 : (clr ? 1'b0 : mdl_ovf2);
            if (sw) mdl_active = mdl_inactive;
            if (acc) begin
                mdl_inactive   = wgt;
                exp_weight_out = wgt;
            end
            exp_switch_out = sw;
            exp_input_out  = act;
            exp_valid0     = vld;
        end else begin
            exp_valid0 = 1'b0;
        end
        @(posedge clk);
        #1;
        check_fwd();
    endtask

    task automatic clear_inputs();
        vld = 1'b0; acc = 1'b0; sw = 1'b0; byp = 1'b0; clr = 1'b0;
    endtask

    task automatic load_w(input logic [15:0] w);
        acc = 1'b1; wgt = w; tick(); acc = 1'b0;
    endtask

    task automatic do_switch();
        sw = 1'b1; tick(); sw = 1'b0;
    endtask

    task automatic set_active(input logic [15:0] w);
        load_w(w); do_switch();
    endtask

    task automatic mac(input logic [15:0] a, input logic [15:0] p);
        vld = 1'b1; act = a; psm = p; tick(); vld = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #1;
        check("rst_psum", 32'(if0.pe_psum_out), 32'h0);
        check("rst_valid", 32'(if0.pe_valid_out), 32'h0);
        check("rst_ovf", 32'(if0.pe_overflow_out), 32'h0);
        check("rst_weight_out", 32'(if0.pe_weight_out), 32'h0);
        check("rst_psum1", 32'(if1.pe_psum_out), 32'h0);
        #6;
        rst = 1'b1;
        en  = 1'b1;

        // 1: load, switch+accept together, switch, MAC
        load_w(16'h4500);
        check("w_out_first", 32'(if0.pe_weight_out), 32'h4500);
        acc = 1'b1; wgt = 16'h0A00; sw = 1'b1; tick(); clear_inputs();
        check("w_out_second", 32'(if0.pe_weight_out), 32'h0A00);
        do_switch();
        mac(16'h0200, 16'h0180);
        check("mac_21_5", 32'(if0.pe_psum_out), 32'h1580);
        check("mac_valid", 32'(if0.pe_valid_out), 32'h1);
        tick();
        check("idle_psum", 32'(if0.pe_psum_out), 32'h0);

        // 2: saturation, sticky flag, clear, set-wins
        set_active(16'h6400);
        mac(16'h0200, 16'h0000);
        check("sat_pos", 32'(if0.pe_psum_out), 32'h7FFF);
        check("sat_pos_ovf", 32'(if0.pe_overflow_out), 32'h1);
        tick();
        check("ovf_sticky", 32'(if0.pe_overflow_out), 32'h1);
        clr = 1'b1; tick(); clr = 1'b0;
        check("ovf_cleared", 32'(if0.pe_overflow_out), 32'h0);
        set_active(16'h9C00);
        mac(16'h0200, 16'h0000);
        check("sat_neg", 32'(if0.pe_psum_out), 32'h8000);
        clr = 1'b1; mac(16'h0200, 16'h0000); clr = 1'b0;
        check("set_wins", 32'(if0.pe_overflow_out), 32'h1);
        clr = 1'b1; tick(); clr = 1'b0;

        // 3: rounding, sign, most-negative squared
        set_active(16'h0080);
        mac(16'h0001, 16'h0000);
        check("round_up", 32'(if0.pe_psum_out), 32'h0001);
        mac(16'hFFFF, 16'h0000);
        check("round_neg", 32'(if0.pe_psum_out), 32'h0000);
        set_active(16'hFD00);
        mac(16'h0200, 16'h0000);
        check("neg_product", 32'(if0.pe_psum_out), 32'hFA00);
        set_active(16'h8000);
        mac(16'h8000, 16'h8000);
        check("min_squared", 32'(if0.pe_psum_out), 32'h7FFF);
        clr = 1'b1; tick(); clr = 1'b0;

        // 4: switch timing under continuous valid
        set_active(16'h0100);
        load_w(16'h0300);
        vld = 1'b1; act = 16'h0100; psm = 16'h0000;
        sw = 1'b1; tick(); sw = 1'b0;
        check("sw_old_weight", 32'(if0.pe_psum_out), 32'h0100);
        tick();
        check("sw_new_weight", 32'(if0.pe_psum_out), 32'h0300);
        check("sw_out_drop", 32'(if0.pe_switch_out), 32'h0);
        clear_inputs();
        tick();

        // 5: back-to-back with a disable gap; dut1 latency 2
        set_active(16'h0180);
        tick();
        mac(16'h0100, 16'h0010);
        check("pipe_lat_empty", 32'(if1.pe_valid_out), 32'h0);
        mac(16'h0200, 16'h0020);
        check("pipe_first", 32'(if1.pe_valid_out), 32'h1);
        en = 1'b0; vld = 1'b1; act = 16'h7777; psm = 16'h1111;
        tick();
        check("dis_valid1", 32'(if1.pe_valid_out), 32'h0);
        tick();
        vld = 1'b0; en = 1'b1;
        mac(16'h0300, 16'h0030);
        check("resume_1", 32'(if1.pe_valid_out), 32'h1);
        mac(16'h0400, 16'h0040);
        check("resume_2", 32'(if1.pe_valid_out), 32'h1);
        tick();
        check("drain_1", 32'(if1.pe_valid_out), 32'h1);
        tick();
        check("drain_2", 32'(if1.pe_valid_out), 32'h0);

        // randomised traffic against the model
        for (int i = 0; i < 40; i++) begin
            en  = ($urandom_range(0, 7) != 0);
            vld = $urandom_range(0, 1);
            byp = ($urandom_range(0, 3) == 0);
            acc = $urandom_range(0, 1);
            sw  = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 7) == 0);
            act = 16'($urandom_range(0, 65535));
            wgt = 16'($urandom_range(0, 65535));
            psm = 16'($urandom_range(0, 65535));
            tick();
        end
        clear_inputs();
        en = 1'b1;
        tick(); tick(); tick();

        // 6: bypass keeps the flag, then async reset mid-stream
        set_active(16'h6400);
        mac(16'h0200, 16'h0000);
        byp = 1'b1; mac(16'h5555, 16'h1234); byp = 1'b0;
        check("bypass_psum", 32'(if0.pe_psum_out), 32'h1234);
        check("bypass_ovf", 32'(if0.pe_overflow_out), 32'h1);
        vld = 1'b1; act = 16'h0100; psm = 16'h0001;
        tick();
        clear_inputs();
        #2;
        rst = 1'b0;
        #1;
        check("arst_psum", 32'(if0.pe_psum_out), 32'h0);
        check("arst_valid", 32'(if0.pe_valid_out), 32'h0);
        check("arst_ovf", 32'(if0.pe_overflow_out), 32'h0);
        check("arst_wout", 32'(if0.pe_weight_out), 32'h0);
        check("arst_in_out", 32'(if0.pe_input_out), 32'h0);
        check("arst_psum1", 32'(if1.pe_psum_out), 32'h0);
        exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
        mdl_active = '0; mdl_inactive = '0; mdl_ovf0 = 1'b0; mdl_ovf2 = 1'b0;
        exp_weight_out = '0; exp_input_out = '0; exp_switch_out = 1'b0; exp_valid0 = 1'b0;
        act = '0; psm = '0; wgt = '0;
        @(posedge clk);
        #1;
        check("arst_held_valid1", 32'(if1.pe_valid_out), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        mac(16'h0100, 16'h0005);
        check("zero_weight", 32'(if0.pe_psum_out), 32'h0005);
        do_switch();
        mac(16'h0100, 16'h0006);
        check("zero_inactive", 32'(if0.pe_psum_out), 32'h0006);
        tick(); tick(); tick();

        check("q0_drained", 32'(exp_q0.size()), 32'h0);
        check("q1_drained", 32'(exp_q1.size()), 32'h0);
        check("q2_drained", 32'(exp_q2.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_gen.md
Name: pe_gen

Overview:
Parametrised successor to the systolic processing element (PE) for the tiny-tpu array, in signed fixed point (Q(DATA_W-FRAC_W).FRAC_W).
- Keeps the double-buffered weights: one register loads while the other computes, and a switch pulse swaps them.
- Adds configurable width, an optional multiply pipeline stage, round-half-up, saturating accumulation with a sticky overflow flag, bypass mode, and switch forwarding so a whole column swaps weights in a wavefront.
- Tiles into the systolic array: inputs flow east, weights and psums flow south.

Parameters:
DATA_W, 16, width of input/weight/psum words, signed two's complement
FRAC_W, 8, fractional bits; must satisfy 1 <= FRAC_W < DATA_W
MUL_PIPE, 0, 0 = psum/valid latency 1 cycle; 1 = extra product register, latency 2
SATURATE, 1, 1 = clamp sum to the signed DATA_W range; 0 = wrap

Ports:
clk  in  1  clock, all state on the rising edge
rst  in  1  reset, asynchronous, active-low
pe_enabled  in  1  0 freezes all state
pe_valid_in  in  1  input/psum pair valid this cycle
pe_accept_w_in  in  1  load pe_weight_in into the inactive weight register
pe_switch_in  in  1  copy inactive weight to active weight
pe_bypass_in  in  1  psum passes through unmodified
pe_clear_ovf_in  in  1  clear sticky overflow
pe_input_in  in  DATA_W  activation
pe_weight_in  in  DATA_W  weight shifting in from above
pe_psum_in  in  DATA_W  partial sum from above
pe_valid_out  out  1  aligned with pe_psum_out
pe_switch_out  out  1  pe_switch_in delayed 1 cycle
pe_input_out  out  DATA_W  pe_input_in delayed 1 cycle
pe_weight_out  out  DATA_W  pe_weight_in registered when accepted
pe_psum_out  out  DATA_W  result
pe_overflow_out  out  1  sticky saturation flag

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs are 0;
  - weight_reg_active = weight_reg_inactive = 0;
  - pipeline registers are 0.
  - Reset mid-operation discards in-flight data.
- Disable (pe_enabled=0): every register holds its value except pe_valid_out, which goes to 0.
  - This includes the pipeline stage, so nothing is lost when the PE is re-enabled.
- Weight load (pe_accept_w_in=1): weight_reg_inactive and pe_weight_out take pe_weight_in on the edge.
  - When not accepting, both hold.
- Switch (pe_switch_in=1): weight_reg_active takes the pre-edge weight_reg_inactive.
  - Switch and accept in the same cycle: active gets the old inactive, inactive gets the new weight.
  - pe_switch_out is pe_switch_in delayed 1 cycle, unconditionally (only pe_enabled gates it).
- MAC timing: the MAC always uses the pre-edge weight_reg_active. A switch therefore affects only the next cycle's input.
- pe_input_out is pe_input_in delayed 1 cycle, regardless of valid.
- Arithmetic, when valid_in=1 and bypass=0:
  - p = input * active, signed, 2*DATA_W bits;
  - r = (p + 2^(FRAC_W-1)) >>> FRAC_W, arithmetic shift (round half up);
  - s = r + sign-extended psum_in, computed at 2*DATA_W+1 bits.
- Result width:
  - SATURATE=1: clamp s to [-2^(DATA_W-1), 2^(DATA_W-1)-1], and set overflow if clamping occurred.
  - SATURATE=0: truncate s to DATA_W bits; overflow is set if the truncation changed the value.
- Bypass (valid_in=1, bypass=1): psum_out = psum_in, overflow unaffected.
- Idle (valid_in=0): psum_out = 0 and valid_out = 0.
- Latency: valid_out and psum_out follow the inputs by 1+MUL_PIPE cycles.
  - With MUL_PIPE=1, stage 1 registers r, psum_in, valid and bypass; stage 2 does the add and saturation.
- Overflow flag:
  - set when a saturating result is produced;
  - cleared by pe_clear_ovf_in;
  - set and clear in the same cycle: set wins.
- Back-to-back valid: one result per cycle, no bubbles.

Decomposition:
- pe_pkg holds:
  - the mode and latency localparams;
  - a sat_trunc function (value, width) returning the result and an overflow bit;
  - the round-half-up constant helper.
- One sub-module, pe_mac: multiply, round, optional pipeline register, add and saturate.
- pe_gen holds the weight double-buffer, forwarding registers and the sticky flag.

Test Plan:
1. Load, switch, MAC: accept 0x4500 (69.0), next cycle accept 0x0A00 (10.0) with switch=1 → inactive=0x0A00, active=0x4500, weight_out=0x0A00. Then switch=1 again, then valid with input 0x0200 (2.0), psum 0x0180 (1.5) → psum_out 0x1580 (21.5) after 1 cycle, valid_out=1.
2. Saturation and flag: active=0x6400 (100.0), input=0x0200 (2.0), psum 0 → psum_out 0x7FFF, overflow=1 and stays 1. Then clear_ovf → overflow=0. Negative case: -100.0 × 2.0 → 0x8000.
3. Rounding: active=0x0080 (0.5), input=0x0001 → psum_out 0x0001. Input 0xFFFF → psum_out 0x0000. Sign check: -3.0 × 2.0 → 0xFA00.
4. Switch timing: hold valid high, toggle switch between two weights → the weight change appears on the result exactly one input later. switch_out must be delayed 1 cycle.
5. MUL_PIPE=1 build: 4 back-to-back valids → 4 results at latency 2, no gaps. Deassert pe_enabled mid-stream for 2 cycles → results resume intact.
6. Async reset mid-stream: drop rst between edges → all outputs 0 immediately, weights 0. Bypass check: valid with bypass=1, psum_in 0x1234 → psum_out 0x1234, overflow unchanged.
